// File: rtl/bw_mult_rr_arbiter.sv
// Round-robin front end sharing one 4x4 signed Baugh-Wooley multiplier.
// Stage 1 captures the winner's operands; stage 2 holds the product and owner ID.
module bw_mult_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] A_bus,
  input  logic [4*N_REQ-1:0] B_bus,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         AB,
  output logic               AB_valid,
  output logic [ID_W-1:0]    AB_id,
  input  logic               out_ready
);

  generate
    if (N_REQ < 2 || N_REQ > 8 || N_REQ > (1 << ID_W)) begin : g_bad_cfg
      $error("bw_mult_rr_arbiter: illegal N_REQ/ID_W");
    end
  endgenerate

  logic            s1_valid;
  logic [3:0]      s1_a;
  logic [3:0]      s1_b;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] win;
  logic [N_REQ-1:0] rot;
  logic            found;
  logic            granted;
  logic            adv2;
  logic            accept;
  logic [3:0]      sel_a;
  logic [3:0]      sel_b;
  logic [7:0]      prod;
  logic            pp;

  assign adv2   = s1_valid & (~AB_valid | out_ready);
  assign accept = ~s1_valid | adv2;

  // Rotate so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    rot   = N_REQ'({req, req} >> ptr);
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = ID_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    gnt   = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == win) begin
        gnt[i] = found & accept & ~rst;
        sel_a  = A_bus[4*i +: 4];
        sel_b  = B_bus[4*i +: 4];
      end
    end
  end

  assign granted = |gnt;
  assign ptr_nxt = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);

  // Baugh-Wooley: invert mixed-sign partial products, add 2^4 + 2^7.
  always_comb begin
    prod = 8'h90;
    pp   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp = s1_a[i] & s1_b[j];
        if ((i == 3) != (j == 3)) pp = ~pp;
        prod = prod + (8'(pp) << (i + j));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else if (granted) begin
      s1_valid <= 1'b1;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_id    <= win;
      ptr      <= ptr_nxt;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AB       <= '0;
      AB_valid <= 1'b0;
      AB_id    <= '0;
    end else if (adv2) begin
      AB       <= prod;
      AB_valid <= 1'b1;
      AB_id    <= s1_id;
    end else if (AB_valid & out_ready & ~s1_valid) begin
      AB_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bw_mult_rr_arbiter.sv
// Bench for bw_mult_rr_arbiter: scenario tasks checked against
// an in-order result queue and a round-robin search model.
module tb_bw_mult_rr_arbiter;

  localparam int N = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [4*N-1:0] A_bus = '0;
  logic [4*N-1:0] B_bus = '0;
  logic [N-1:0]  gnt;
  logic [7:0]    AB;
  logic          AB_valid;
  logic [IW-1:0] AB_id;
  logic          out_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  bw_mult_rr_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .A_bus(A_bus), .B_bus(B_bus),
    .gnt(gnt), .AB(AB), .AB_valid(AB_valid), .AB_id(AB_id),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    p;
    logic [IW-1:0] id;
    int            age;
  } item_t;

  item_t        mq[$];
  int           m_ptr = 0;
  logic [N-1:0] last_g = '0;

  function automatic logic [N-1:0] m_gnt();
    int idx;
    if (rst) return '0;
    if (mq.size() >= 2 && !out_ready) return '0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req[idx]) return N'(1 << idx);
    end
    return '0;
  endfunction

  function automatic logic m_valid();
    return (mq.size() > 0) && (mq[0].age >= 2);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ptr  = 0;
    last_g = '0;
  endtask

  task automatic m_edge();
    logic [N-1:0] g;
    logic signed [3:0] a;
    logic signed [3:0] b;
    item_t t;
    g = m_gnt();
    if (m_valid() && out_ready) void'(mq.pop_front());
    for (int i = 0; i < mq.size(); i++) begin
      t = mq[i];
      t.age++;
      mq[i] = t;
    end
    for (int w = 0; w < N; w++) begin
      if (g[w]) begin
        a = A_bus[4*w +: 4];
        b = B_bus[4*w +: 4];
        t.p = 8'(int'(a) * int'(b));
        t.id = IW'(w);
        t.age = 1;
        mq.push_back(t);
        m_ptr = (w + 1) % N;
      end
    end
    last_g = g;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    A_bus[4*i +: 4] = a;
    B_bus[4*i +: 4] = b;
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < N; i++) begin
      if (last_g[i] || !req[i]) begin
        req[i] = ($urandom_range(0, 99) < pct);
        set_op(i, 4'($urandom), 4'($urandom));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '1;
    for (int i = 0; i < N; i++) set_op(i, 4'($urandom), 4'($urandom));
    #3;
    tests++;
    if (gnt !== '0) begin
      fails++; $display("FAIL reset_gnt: got %b want 0", gnt);
    end
    tests++;
    if (AB_valid !== 1'b0 || AB !== 8'd0 || AB_id !== '0) begin
      fails++;
      $display("FAIL reset_out: got v=%b ab=%0d id=%0d want 0/0/0", AB_valid, AB, AB_id);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    m_reset();
  endtask

  task automatic test_single();
    logic [N-1:0] eg;
    req = 4'b0001;
    set_op(0, 4'd3, 4'd7);
    for (int c = 0; c < 5; c++) begin
      #3;
      eg = m_gnt();
      tests++;
      if (gnt !== eg || (c == 0 && gnt !== 4'b0001)) begin
        fails++; $display("FAIL single_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      tests++;
      if (AB_valid !== (c == 2) || AB_valid !== m_valid()) begin
        fails++; $display("FAIL single_valid c%0d: got %b want %b", c, AB_valid, c == 2);
      end
      if (c == 2) begin
        tests++;
        if (AB !== 8'd21 || AB_id !== 2'd0) begin
          fails++; $display("FAIL single_ab: got %0d id %0d want 21 id 0", $signed(AB), AB_id);
        end
      end
      m_edge();
      @(posedge clk); #1;
      req = '0;
    end
  endtask

  task automatic test_signed_corners();
    logic [3:0] ta[4];
    logic [3:0] tb[4];
    logic [7:0] te[4];
    logic [N-1:0] eg;
    int k;
    int n;
    ta = '{4'h8, 4'h8, 4'hD, 4'h0};
    tb = '{4'h8, 4'h7, 4'h9, 4'hF};
    te = '{8'd64, 8'hC8, 8'd21, 8'd0};
    k = 0;
    n = 0;
    req = 4'b0100;
    set_op(2, ta[0], tb[0]);
    for (int c = 0; c < 8; c++) begin
      #3;
      eg = m_gnt();
      tests++;
      if (gnt !== eg) begin
        fails++; $display("FAIL corners_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      tests++;
      if (AB_valid !== m_valid()) begin
        fails++; $display("FAIL corners_valid c%0d: got %b want %b", c, AB_valid, m_valid());
      end
      if (AB_valid && n < 4) begin
        tests++;
        if (AB !== te[n] || AB_id !== 2'd2 || c != n + 2) begin
          fails++;
          $display("FAIL corners_ab #%0d c%0d: got %0d id %0d want %0d id 2",
                   n, c, $signed(AB), AB_id, $signed(te[n]));
        end
        n++;
      end
      m_edge();
      @(posedge clk); #1;
      if (last_g[2]) begin
        k++;
        if (k < 4) set_op(2, ta[k], tb[k]);
        else req = '0;
      end
    end
    tests++;
    if (n != 4) begin
      fails++; $display("FAIL corners_count: got %0d want 4", n);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    logic [N-1:0] want;
    rst = 1'b1;
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      req = (c < 8) ? 4'b1111 : (c < 12) ? 4'b0101 : 4'b0000;
      for (int i = 0; i < N; i++) set_op(i, 4'($urandom), 4'($urandom));
      #3;
      eg = m_gnt();
      want = (c < 8) ? 4'(1 << (c % 4)) : (c < 12) ? ((c % 2) ? 4'b0100 : 4'b0001) : 4'b0000;
      tests++;
      if (gnt !== eg || gnt !== want) begin
        fails++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, want);
      end
      tests++;
      if (AB_valid !== m_valid()) begin
        fails++; $display("FAIL rr_valid c%0d: got %b want %b", c, AB_valid, m_valid());
      end
      if (m_valid()) begin
        tests++;
        if (AB !== mq[0].p || AB_id !== mq[0].id) begin
          fails++;
          $display("FAIL rr_ab c%0d: got %0d id %0d want %0d id %0d",
                   c, $signed(AB), AB_id, $signed(mq[0].p), mq[0].id);
        end
      end
      m_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] eg;
    logic [7:0] held;
    logic was_stall;
    int zero_g;
    zero_g = 0;
    was_stall = 1'b0;
    held = '0;
    req = 4'b0011;
    set_op(0, 4'($urandom), 4'($urandom));
    set_op(1, 4'($urandom), 4'($urandom));
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      if (c >= 8) req = '0;
      #3;
      eg = m_gnt();
      tests++;
      if (gnt !== eg) begin
        fails++; $display("FAIL bp_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      if (c >= 2 && c <= 5 && gnt == '0) zero_g++;
      tests++;
      if (AB_valid !== m_valid()) begin
        fails++; $display("FAIL bp_valid c%0d: got %b want %b", c, AB_valid, m_valid());
      end
      if (m_valid()) begin
        tests++;
        if (AB !== mq[0].p || AB_id !== mq[0].id || (was_stall && AB !== held)) begin
          fails++;
          $display("FAIL bp_ab c%0d: got %0d id %0d want %0d id %0d",
                   c, $signed(AB), AB_id, $signed(mq[0].p), mq[0].id);
        end
      end
      was_stall = AB_valid && !out_ready;
      held = AB;
      m_edge();
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        if (last_g[i]) set_op(i, 4'($urandom), 4'($urandom));
    end
    tests++;
    if (zero_g != 4) begin
      fails++; $display("FAIL bp_stall_gnt: got %0d zero-grant cycles want 4", zero_g);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    for (int c = 0; c < 400; c++) begin
      refill(60);
      out_ready = ($urandom_range(0, 3) != 0);
      #3;
      eg = m_gnt();
      tests++;
      if (gnt !== eg) begin
        fails++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      tests++;
      if (AB_valid !== m_valid()) begin
        fails++; $display("FAIL rnd_valid c%0d: got %b want %b", c, AB_valid, m_valid());
      end
      if (m_valid()) begin
        tests++;
        if (AB !== mq[0].p || AB_id !== mq[0].id) begin
          fails++;
          $display("FAIL rnd_ab c%0d: got %0d id %0d want %0d id %0d",
                   c, $signed(AB), AB_id, $signed(mq[0].p), mq[0].id);
        end
      end
      m_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] eg;
    req = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 4'($urandom), 4'($urandom));
    for (int c = 0; c < 3; c++) begin
      #3;
      eg = m_gnt();
      tests++;
      if (gnt !== eg) begin
        fails++; $display("FAIL mid_fill_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      m_edge();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (last_g[i]) set_op(i, 4'($urandom), 4'($urandom));
    end
    tests++;
    if (AB_valid !== 1'b1 || mq.size() != 2) begin
      fails++; $display("FAIL mid_full: got v=%b want 1", AB_valid);
    end
    #1;
    rst = 1'b1;
    m_reset();
    req = 4'b1000;
    #1;
    tests++;
    if (AB_valid !== 1'b0 || AB !== 8'd0 || gnt !== '0) begin
      fails++;
      $display("FAIL mid_async: got v=%b ab=%0d gnt=%b want 0/0/0", AB_valid, AB, gnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) req = '0;
      #3;
      eg = m_gnt();
      tests++;
      if (gnt !== eg || (c == 0 && gnt !== 4'b0001)) begin
        fails++; $display("FAIL mid_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      tests++;
      if (AB_valid !== m_valid()) begin
        fails++; $display("FAIL mid_valid c%0d: got %b want %b", c, AB_valid, m_valid());
      end
      if (m_valid()) begin
        tests++;
        if (AB !== mq[0].p || AB_id !== mq[0].id) begin
          fails++;
          $display("FAIL mid_ab c%0d: got %0d id %0d want %0d id %0d",
                   c, $signed(AB), AB_id, $signed(mq[0].p), mq[0].id);
        end
      end
      m_edge();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_signed_corners();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
